// File: rtl/aes_host_bridge_pkg.sv
// Shared definitions for the AES host bridge.
// Contents: stream word type encodings, the block size in 16-bit words,
// the bridge state enum and a helper that classifies command types.
package aes_host_bridge_pkg;

  localparam logic [1:0] TYPE_DATA       = 2'b00;
  localparam logic [1:0] TYPE_KEY        = 2'b01;
  localparam int         WORDS_PER_BLOCK = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_SEND     = 3'd2,
    ST_COLLECT  = 3'd3,
    ST_RESP     = 3'd4
  } state_t;

  // True for the two command types the core understands.
  function automatic logic is_known_type(input logic [1:0] t);
    return (t == TYPE_DATA) || (t == TYPE_KEY);
  endfunction

endpackage

// File: rtl/aes_host_bridge_word_shifter.sv
// 128-bit load / MSW-first shift register with a 3-bit word counter.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   load, load_data parallel load; also clears the word counter
//   shift, shift_in shift left by one 16-bit word, shift_in enters the LSW
//   data            current register contents (MSW is data[127:112])
//   count           number of shifts since the last load, modulo 8
module aes_word_shifter
  import aes_host_bridge_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [127:0] load_data,
  input  logic         shift,
  input  logic [15:0]  shift_in,
  output logic [127:0] data,
  output logic [2:0]   count
);

  // Shift register and word counter; load takes priority over shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= 128'h0;
      count <= 3'd0;
    end else if (load) begin
      data  <= load_data;
      count <= 3'd0;
    end else if (shift) begin
      data  <= {data[111:0], shift_in};
      count <= count + 3'd1;
    end else begin
      data  <= data;
      count <= count;
    end
  end

endmodule

// File: rtl/aes_host_bridge.sv
// Host-side initiator for the AES core 16-bit stream interface.
// A 128-bit key or data command is serialised MSW first as 8 words on
// data_in; for data commands the 8 result words on data_out are then
// gathered into one 128-bit response.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_type/cmd_mode/cmd_data   host command
//   data_in_valid/data_in_type/data_in               words toward the core
//   crypto_mode                      latched direction for the operation
//   crypto_ready                     core ready for a data block
//   data_out_valid/data_out_type/data_out            result words from core
//   rsp_valid/rsp_ready/rsp_type/rsp_data            host response
//   timeout                          one-cycle pulse on abandoned collect
module aes_host_bridge
  import aes_host_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TW             = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_type,
  input  logic         cmd_mode,
  input  logic [127:0] cmd_data,
  output logic         data_in_valid,
  output logic [1:0]   data_in_type,
  output logic [15:0]  data_in,
  output logic         crypto_mode,
  input  logic         crypto_ready,
  input  logic         data_out_valid,
  input  logic         data_out_type,
  input  logic [15:0]  data_out,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_type,
  output logic [127:0] rsp_data,
  output logic         timeout
);

  localparam logic [2:0] LAST_WORD = 3'(WORDS_PER_BLOCK - 1);

  state_t         state;
  state_t         state_next;
  logic [1:0]     typ_q;
  logic           mode_q;
  logic           rsp_type_q;
  logic [TW-1:0]  tcnt;
  logic           accept;
  logic           tmo_hit;
  logic           coll_word;
  logic           coll_load;
  logic [127:0]   ser_data;
  logic [2:0]     ser_cnt;
  logic [127:0]   coll_data;
  logic [2:0]     coll_cnt;
  logic           unused_ser_bits;

  assign accept    = (state == ST_IDLE) && cmd_valid;
  assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (tcnt == TW'(TIMEOUT_CYCLES));
  // A word arriving in the same cycle the timeout fires is dropped with
  // the rest of the abandoned block.
  assign coll_word = (state == ST_COLLECT) && data_out_valid && !tmo_hit;
  // Keep the collector zeroed whenever no result is being gathered or
  // presented, so an abandoned partial result never leaks into the next one.
  assign coll_load = (state != ST_COLLECT) && (state != ST_RESP);

  // Only the outgoing MSW of the serialiser is ever observed.
  assign unused_ser_bits = ^ser_data[111:0];

  aes_word_shifter u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_data (cmd_data),
    .shift     (state == ST_SEND),
    .shift_in  (16'h0000),
    .data      (ser_data),
    .count     (ser_cnt)
  );

  aes_word_shifter u_coll (
    .clk       (clk),
    .rst       (rst),
    .load      (coll_load),
    .load_data (128'h0),
    .shift     (coll_word),
    .shift_in  (data_out),
    .data      (coll_data),
    .count     (coll_cnt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (cmd_valid && is_known_type(cmd_type)) begin
          state_next = (cmd_type == TYPE_KEY) ? ST_SEND : ST_WAIT_RDY;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT_RDY: begin
        if (crypto_ready) begin
          state_next = ST_SEND;
        end else begin
          state_next = ST_WAIT_RDY;
        end
      end
      ST_SEND: begin
        if (ser_cnt == LAST_WORD) begin
          state_next = (typ_q == TYPE_KEY) ? ST_IDLE : ST_COLLECT;
        end else begin
          state_next = ST_SEND;
        end
      end
      ST_COLLECT: begin
        if (tmo_hit) begin
          state_next = ST_IDLE;
        end else if (coll_word && (coll_cnt == LAST_WORD)) begin
          state_next = ST_RESP;
        end else begin
          state_next = ST_COLLECT;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_RESP;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Command attributes latched at acceptance, held for the operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      typ_q  <= 2'b00;
      mode_q <= 1'b0;
    end else if (accept) begin
      typ_q  <= cmd_type;
      mode_q <= cmd_mode;
    end else begin
      typ_q  <= typ_q;
      mode_q <= mode_q;
    end
  end

  // Inter-word idle counter: cleared outside COLLECT and on every word,
  // frozen once it reaches the limit (the state leaves COLLECT next edge).
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
    end else if ((state != ST_COLLECT) || coll_word) begin
      tcnt <= '0;
    end else if ((TIMEOUT_CYCLES != 0) && !tmo_hit) begin
      tcnt <= tcnt + TW'(1);
    end else begin
      tcnt <= tcnt;
    end
  end

  // Response type comes from the first result word of the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_type_q <= 1'b0;
    end else if (coll_word && (coll_cnt == 3'd0)) begin
      rsp_type_q <= data_out_type;
    end else begin
      rsp_type_q <= rsp_type_q;
    end
  end

  // Outputs decoded from registered state; stream and response buses are
  // forced to zero when not valid.
  always_comb begin
    cmd_ready     = 1'b0;
    data_in_valid = 1'b0;
    data_in_type  = 2'b00;
    data_in       = 16'h0000;
    crypto_mode   = mode_q;
    rsp_valid     = 1'b0;
    rsp_type      = 1'b0;
    rsp_data      = 128'h0;
    timeout       = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
      end
      ST_SEND: begin
        data_in_valid = 1'b1;
        data_in_type  = typ_q;
        data_in       = ser_data[127:112];
      end
      ST_COLLECT: begin
        timeout = tmo_hit;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_type  = rsp_type_q;
        rsp_data  = coll_data;
      end
      default: begin
        cmd_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_host_bridge.sv
// Directed self-checking bench for aes_host_bridge (timeout shortened to 16).
module tb_aes_host_bridge;
  import aes_host_bridge_pkg::*;

  logic         clk;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_type;
  logic         cmd_mode;
  logic [127:0] cmd_data;
  logic         data_in_valid;
  logic [1:0]   data_in_type;
  logic [15:0]  data_in;
  logic         crypto_mode;
  logic         crypto_ready;
  logic         data_out_valid;
  logic         data_out_type;
  logic [15:0]  data_out;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_type;
  logic [127:0] rsp_data;
  logic         timeout;

  int n_vec  = 0;
  int n_miss = 0;

  logic [15:0] key_words [0:7] = '{16'h0001, 16'h0203, 16'h0405, 16'h0607,
                                   16'h0809, 16'h0a0b, 16'h0c0d, 16'h0e0f};
  logic [15:0] blk_words [0:7] = '{16'h0011, 16'h2233, 16'h4455, 16'h6677,
                                   16'h8899, 16'haabb, 16'hccdd, 16'heeff};
  logic [15:0] res_words [0:7] = '{16'h69c4, 16'he0d8, 16'h6a7b, 16'h0430,
                                   16'hd8cd, 16'hb780, 16'h70b4, 16'hc55a};
  logic [15:0] res2_words [0:7] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                                    16'h5555, 16'h6666, 16'h7777, 16'h8888};

  aes_host_bridge #(.TIMEOUT_CYCLES(16), .TW(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_type       (cmd_type),
    .cmd_mode       (cmd_mode),
    .cmd_data       (cmd_data),
    .data_in_valid  (data_in_valid),
    .data_in_type   (data_in_type),
    .data_in        (data_in),
    .crypto_mode    (crypto_mode),
    .crypto_ready   (crypto_ready),
    .data_out_valid (data_out_valid),
    .data_out_type  (data_out_type),
    .data_out       (data_out),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_type       (rsp_type),
    .rsp_data       (rsp_data),
    .timeout        (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one command for a single cycle; returns just after the accepting edge.
  task automatic send_cmd(input logic [1:0] t, input logic m, input logic [127:0] d);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_mode  = m;
    cmd_data  = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_type = 2'b00; cmd_mode = 1'b0; cmd_data = 128'h0;
    crypto_ready = 1'b0; data_out_valid = 1'b0; data_out_type = 1'b0; data_out = 16'h0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_cmd_ready", 128'(cmd_ready), 128'(1'b1));
    check("rst_din_valid", 128'(data_in_valid), 128'(1'b0));
    check("rst_din", 128'(data_in), 128'(16'h0));
    check("rst_rsp_valid", 128'(rsp_valid), 128'(1'b0));
    check("rst_timeout", 128'(timeout), 128'(1'b0));
    check("rst_rsp_data", rsp_data, 128'h0);

    // Key load
    send_cmd(2'b01, 1'b0, 128'h000102030405060708090a0b0c0d0e0f);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("key_valid", 128'(data_in_valid), 128'(1'b1));
      check("key_word", 128'(data_in), 128'(key_words[k]));
      check("key_type", 128'(data_in_type), 128'(2'b01));
      check("key_no_rsp", 128'(rsp_valid), 128'(1'b0));
    end
    @(negedge clk);
    check("key_end_valid", 128'(data_in_valid), 128'(1'b0));
    check("key_end_ready", 128'(cmd_ready), 128'(1'b1));

    // Data path with crypto_ready already high
    crypto_ready = 1'b1;
    send_cmd(2'b00, 1'b0, 128'h00112233445566778899aabbccddeeff);
    @(negedge clk);
    check("dat_wait_valid", 128'(data_in_valid), 128'(1'b0));
    check("dat_wait_ready", 128'(cmd_ready), 128'(1'b0));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("dat_word", 128'(data_in), 128'(blk_words[k]));
      check("dat_type", 128'(data_in_type), 128'(2'b00));
      check("dat_mode", 128'(crypto_mode), 128'(1'b0));
    end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      data_out_valid = 1'b1;
      data_out_type  = (k == 0);
      data_out       = res_words[k];
      @(negedge clk);
      check("dat_rsp_early", 128'(rsp_valid), 128'(1'b0));
    end
    @(posedge clk); #1;
    data_out_valid = 1'b0; data_out_type = 1'b0;
    @(negedge clk);
    check("dat_rsp_valid", 128'(rsp_valid), 128'(1'b1));
    check("dat_rsp_data", rsp_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check("dat_rsp_type", 128'(rsp_type), 128'(1'b1));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("dat_rsp_drop", 128'(rsp_valid), 128'(1'b0));
    check("dat_idle_ready", 128'(cmd_ready), 128'(1'b1));

    // Stray result words while idle are ignored
    data_out_valid = 1'b1; data_out = 16'hdead;
    repeat (2) @(negedge clk);
    data_out_valid = 1'b0;
    check("stray_rsp", 128'(rsp_valid), 128'(1'b0));

    // Reserved command type is accepted and dropped
    send_cmd(2'b10, 1'b0, 128'h5555);
    @(negedge clk);
    check("rsv_ready", 128'(cmd_ready), 128'(1'b1));
    check("rsv_valid", 128'(data_in_valid), 128'(1'b0));

    // crypto_ready low for 20 cycles, then a short result (timeout)
    crypto_ready = 1'b0;
    send_cmd(2'b00, 1'b1, 128'hcafebabe_00000000_00000000_00000000);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("crdy_valid", 128'(data_in_valid), 128'(1'b0));
      check("crdy_ready", 128'(cmd_ready), 128'(1'b0));
    end
    @(posedge clk); #1;
    crypto_ready = 1'b1;
    @(negedge clk);
    check("crdy_seen_valid", 128'(data_in_valid), 128'(1'b0));
    @(negedge clk);
    check("crdy_first_valid", 128'(data_in_valid), 128'(1'b1));
    check("crdy_first_word", 128'(data_in), 128'(16'hcafe));
    check("crdy_mode", 128'(crypto_mode), 128'(1'b1));
    repeat (7) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      data_out_valid = 1'b1;
      data_out       = res_words[k];
    end
    @(posedge clk); #1;
    data_out_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("tmo_early", 128'(timeout), 128'(1'b0));
    end
    @(negedge clk);
    check("tmo_pulse", 128'(timeout), 128'(1'b1));
    check("tmo_no_rsp", 128'(rsp_valid), 128'(1'b0));
    @(negedge clk);
    check("tmo_pulse_end", 128'(timeout), 128'(1'b0));
    check("tmo_idle_ready", 128'(cmd_ready), 128'(1'b1));
    check("tmo_no_rsp2", 128'(rsp_valid), 128'(1'b0));

    // Response backpressure with a new command waiting
    send_cmd(2'b00, 1'b0, 128'h0123456789abcdef0123456789abcdef);
    repeat (9) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      data_out_valid = 1'b1;
      data_out       = res2_words[k];
    end
    @(posedge clk); #1;
    data_out_valid = 1'b0;
    @(negedge clk);
    check("bp_rsp_valid", 128'(rsp_valid), 128'(1'b1));
    cmd_valid = 1'b1; cmd_type = 2'b01; cmd_mode = 1'b0;
    cmd_data  = 128'h4321_0000_0000_0000_0000_0000_0000_0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 128'(rsp_valid), 128'(1'b1));
      check("bp_hold_data", rsp_data, 128'h11112222333344445555666677778888);
      check("bp_hold_type", 128'(rsp_type), 128'(1'b0));
      check("bp_cmd_blocked", 128'(cmd_ready), 128'(1'b0));
      check("bp_no_send", 128'(data_in_valid), 128'(1'b0));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_rsp_drop", 128'(rsp_valid), 128'(1'b0));
    check("bp_idle_ready", 128'(cmd_ready), 128'(1'b1));
    check("bp_not_yet", 128'(data_in_valid), 128'(1'b0));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("bp_new_valid", 128'(data_in_valid), 128'(1'b1));
    check("bp_new_word", 128'(data_in), 128'(16'h4321));
    repeat (8) @(negedge clk);

    // Reset in the middle of a key transfer
    send_cmd(2'b01, 1'b1, 128'h000102030405060708090a0b0c0d0e0f);
    repeat (5) @(negedge clk);
    check("mid_word4", 128'(data_in), 128'(16'h0809));
    check("mid_mode", 128'(crypto_mode), 128'(1'b1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_valid", 128'(data_in_valid), 128'(1'b0));
    check("mid_din", 128'(data_in), 128'(16'h0));
    check("mid_type", 128'(data_in_type), 128'(2'b00));
    check("mid_ready", 128'(cmd_ready), 128'(1'b1));
    check("mid_cmode", 128'(crypto_mode), 128'(1'b0));
    check("mid_rsp", 128'(rsp_valid), 128'(1'b0));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mid_no_more", 128'(data_in_valid), 128'(1'b0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/aes_host_bridge.md
Name: aes_host_bridge

Overview:
- Host-side initiator for the AES core's 16-bit stream interface.
- Accepts 128-bit key or data commands and serialises each into 8 16-bit words on the core's input stream (data_in_valid/data_in_type/data_in). For data commands, it then collects the 8 16-bit result words from the core's output stream and returns one 128-bit response.
- Sits between a host/register front end and the AES core top level. It is the other end of the core's stream-in and stream-out protocol.

Parameters:
- TIMEOUT_CYCLES, 1024, maximum idle cycles between result words in COLLECT before the operation is abandoned; 0 disables the timeout.
- TW, 11, width of the timeout counter; must satisfy 2^TW > TIMEOUT_CYCLES.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  bridge can accept a command; high only in IDLE
- cmd_type  in  2  command type: 2'b00 data block, 2'b01 key; 2'b10 and 2'b11 reserved
- cmd_mode  in  1  crypto direction for a data command: 0 encrypt, 1 decrypt
- cmd_data  in  128  key or data block
- data_in_valid  out  1  word valid toward the core
- data_in_type  out  2  type of the word toward the core (equals the latched cmd_type)
- data_in  out  16  word toward the core
- crypto_mode  out  1  latched cmd_mode, held stable for the whole operation
- crypto_ready  in  1  core ready to accept a data block
- data_out_valid  in  1  core result word valid
- data_out_type  in  1  core result word type
- data_out  in  16  core result word
- rsp_valid  out  1  128-bit response valid
- rsp_ready  in  1  host accepts the response
- rsp_type  out  1  data_out_type captured from the first result word
- rsp_data  out  128  assembled result
- timeout  out  1  one-cycle pulse when a collect operation is abandoned

Behaviour:
- Reset:
  - State goes to IDLE; word and timeout counters clear.
  - All outputs are 0 except cmd_ready, which is 1.
  - Reset asserted mid-operation abandons the operation; no partial words are sent afterward.
- States: IDLE, WAIT_RDY, SEND, COLLECT, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid: latch cmd_type, cmd_mode and cmd_data.
  - Key command goes to SEND. Data command goes to WAIT_RDY.
  - Reserved cmd_type: the command is accepted and dropped; the bridge stays in IDLE.
- WAIT_RDY: go to SEND on the first cycle crypto_ready = 1. If crypto_ready is already high on entry, transfer to SEND on the next cycle.
- SEND:
  - data_in_valid is high for exactly 8 consecutive cycles. There is no backpressure.
  - Word k (k = 0..7) is data_in = latched[127-16k -: 16], i.e. MSW first.
  - After word 7: a key command returns to IDLE; a data command goes to COLLECT.
  - data_in_type is held at the latched type while valid, and is 0 otherwise.
- COLLECT:
  - Each data_out_valid shifts data_out into the LSW: rsp_data <= {rsp_data[111:0], data_out}. The first word received therefore ends up in the MSW.
  - rsp_type is captured on the first word.
  - After the 8th word, go to RESP.
  - The timeout counter clears on each received word and otherwise increments. When it reaches TIMEOUT_CYCLES: pulse timeout for one cycle, discard the partial result, return to IDLE.
- RESP:
  - rsp_valid = 1, with rsp_data and rsp_type stable.
  - When rsp_ready = 1, go to IDLE; rsp_valid drops the next cycle.
- Stray data_out_valid in any state other than COLLECT is ignored.
- Latency:
  - Command acceptance to first data_in word: 1 cycle for a key, or 1 cycle after crypto_ready is seen for data.
  - 8th result word to rsp_valid: 1 cycle.
- Simultaneous events: a cmd_valid arriving in the same cycle as the rsp_ready handshake is not accepted, because cmd_ready is 0 in RESP. Only one operation is ever in flight.

Decomposition:
- The shared aes package holds:
  - stream type encodings: TYPE_DATA = 2'b00, TYPE_KEY = 2'b01;
  - WORDS_PER_BLOCK = 8;
  - the state enum.
- One sub-module, aes_word_shifter, provides the 128-bit load and MSW-first shift register with a 3-bit word counter. It is used twice: once for serialising and once for collecting.

Test Plan:
- Key load: key 000102030405060708090a0b0c0d0e0f -> data_in words 0001, 0203, ..., 0e0f on 8 consecutive cycles, with data_in_type = 01; no rsp_valid.
- Data path: data block 00112233445566778899aabbccddeeff with mode 0, result words 69c4, e0d8, 6a7b, 0430, d8cd, b780, 70b4, c55a driven by the model -> rsp_data = 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_valid one cycle after the last word.
- crypto_ready held low for 20 cycles after a data command -> no data_in_valid until 1 cycle after crypto_ready rises; cmd_ready stays 0 throughout.
- TIMEOUT_CYCLES = 16, only 3 result words returned -> one timeout pulse 16 cycles after the 3rd word, no rsp_valid, cmd_ready = 1 the next cycle.
- rsp_ready held low for 10 cycles, with a new command presented during that time -> rsp_data stable and the command not accepted until after the handshake.
- rst asserted at word 4 of SEND -> all outputs 0 and cmd_ready = 1 the next cycle; no further data_in_valid.
